// File: rtl/midi_voice_allocator_pkg.sv
// Shared MIDI constants, parser state encoding and the parser-to-allocator
// event payload for midi_voice_allocator.
package midi_voice_allocator_pkg;

  localparam int unsigned MIDI_DATA_W = 7;

  // Status nibbles (upper four bits of a status byte)
  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] CTRL       = 4'hB;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;

  localparam logic [MIDI_DATA_W-1:0] ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    PS_IDLE  = 3'd0,
    PS_D1    = 3'd1,
    PS_D2    = 3'd2,
    PS_SKIP1 = 3'd3,
    PS_SKIP2 = 3'd4
  } parse_state_e;

  // Completed-message event, valid in the cycle its last byte is accepted
  typedef struct packed {
    logic                   on;
    logic                   off;
    logic                   alloff;
    logic [MIDI_DATA_W-1:0] note;
    logic [MIDI_DATA_W-1:0] vel;
  } midi_event_t;

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser with running status.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   midi_data    incoming MIDI byte
//   midi_valid   midi_data valid this cycle
//   ev_c         combinational event (on/off/all-notes-off + note/velocity),
//                asserted in the cycle the final byte of a message is accepted
module midi_byte_parser
  import midi_voice_allocator_pkg::*;
#(
  parameter bit          OMNI    = 1'b1,
  parameter int unsigned CHANNEL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  midi_data,
  input  logic        midi_valid,
  output midi_event_t ev_c
);

  parse_state_e           state_q, state_d, eff_state;
  logic [7:0]             run_status_q, run_status_d;
  logic                   run_valid_q, run_valid_d;
  logic [MIDI_DATA_W-1:0] d1_q, d1_d;

  // Status types this block acts on, filtered by channel
  function automatic logic status_accepted(input logic [7:0] status);
    logic chan_ok;
    chan_ok = OMNI || (status[3:0] == 4'(CHANNEL));
    return chan_ok && ((status[7:4] == NOTE_OFF) || (status[7:4] == NOTE_ON) ||
                       (status[7:4] == CTRL));
  endfunction

  // Next-state, running status and event decode
  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    run_valid_d  = run_valid_q;
    d1_d         = d1_q;
    ev_c         = '0;
    ev_c.note    = d1_q;
    ev_c.vel     = midi_data[MIDI_DATA_W-1:0];

    // A data byte in IDLE under running status behaves like the first data byte
    eff_state = state_q;
    if (state_q == PS_IDLE && run_valid_q) begin
      eff_state = status_accepted(run_status_q) ? PS_D1 : PS_SKIP1;
    end

    if (midi_valid && midi_data[7]) begin
      if (midi_data[7:4] == 4'hF) begin
        // 0xF0-0xF7 cancel running status; realtime 0xF8-0xFF leaves everything untouched
        if (!midi_data[3]) begin
          run_valid_d = 1'b0;
          state_d     = PS_IDLE;
        end
      end else begin
        run_status_d = midi_data;
        run_valid_d  = 1'b1;
        state_d      = status_accepted(midi_data) ? PS_D1 : PS_SKIP1;
      end
    end else if (midi_valid) begin
      case (eff_state)
        PS_D1: begin
          d1_d    = midi_data[MIDI_DATA_W-1:0];
          state_d = PS_D2;
        end
        PS_D2: begin
          state_d = PS_D1;
          case (run_status_q[7:4])
            NOTE_ON: begin
              if (midi_data[MIDI_DATA_W-1:0] != '0) ev_c.on = 1'b1;
              else                                 ev_c.off = 1'b1;
            end
            NOTE_OFF: ev_c.off    = 1'b1;
            CTRL:     ev_c.alloff = (d1_q == ALL_NOTES_OFF);
            default: ;
          endcase
        end
        PS_SKIP1: begin
          // Program change / channel pressure carry a single data byte
          if ((run_status_q[7:4] == PROG_CHG) || (run_status_q[7:4] == CHAN_PRESS)) begin
            state_d = PS_SKIP1;
          end else begin
            state_d = PS_SKIP2;
          end
        end
        PS_SKIP2: state_d = PS_SKIP1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PS_IDLE;
      run_status_q <= '0;
      run_valid_q  <= 1'b0;
      d1_q         <= '0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      run_valid_q  <= run_valid_d;
      d1_q         <= d1_d;
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: parses MIDI bytes and maps Note On/Off onto
// NUM_VOICES voices (retrigger same note, else lowest free, else steal oldest).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   midi_data/valid    MIDI byte stream, one byte per valid cycle
//   voice_gate         per-voice gate
//   voice_note         per-voice note, bits [7i+6:7i]
//   voice_velocity     per-voice velocity, bits [7i+6:7i]
//   voice_update       one-cycle pulse when a voice's registers change
//   voice_update_idx   index of the changed voice, valid with voice_update
module midi_voice_allocator
  import midi_voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_BITS   = 4,
  parameter bit          OMNI       = 1'b1,
  parameter int unsigned CHANNEL    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    midi_data,
  input  logic                          midi_valid,
  output logic [NUM_VOICES-1:0]         voice_gate,
  output logic [7*NUM_VOICES-1:0]       voice_note,
  output logic [7*NUM_VOICES-1:0]       voice_velocity,
  output logic                          voice_update,
  output logic [$clog2(NUM_VOICES)-1:0] voice_update_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  midi_event_t ev_c;

  logic [NUM_VOICES-1:0]  gate_q, gate_d;
  logic [MIDI_DATA_W-1:0] note_q [NUM_VOICES];
  logic [MIDI_DATA_W-1:0] note_d [NUM_VOICES];
  logic [MIDI_DATA_W-1:0] vel_q  [NUM_VOICES];
  logic [MIDI_DATA_W-1:0] vel_d  [NUM_VOICES];
  logic [AGE_BITS-1:0]    age_q  [NUM_VOICES];
  logic [AGE_BITS-1:0]    age_d  [NUM_VOICES];
  logic                   update_q, update_d;
  logic [IDX_W-1:0]       update_idx_q, update_idx_d;

  logic                   hit, free, off_hit;
  logic [IDX_W-1:0]       hit_idx, free_idx, old_idx, sel_idx, off_idx;
  logic [AGE_BITS-1:0]    old_age;

  midi_byte_parser #(
    .OMNI    (OMNI),
    .CHANNEL (CHANNEL)
  ) u_parser (
    .clk        (clk),
    .rst_n      (rst_n),
    .midi_data  (midi_data),
    .midi_valid (midi_valid),
    .ev_c       (ev_c)
  );

  // Voice selection and register update for the current event
  always_comb begin
    gate_d       = gate_q;
    note_d       = note_q;
    vel_d        = vel_q;
    age_d        = age_q;
    update_d     = 1'b0;
    update_idx_d = update_idx_q;
    hit          = 1'b0;
    hit_idx      = '0;
    free         = 1'b0;
    free_idx     = '0;
    old_idx      = '0;
    old_age      = '0;
    off_hit      = 1'b0;
    off_idx      = '0;

    // Candidates: lowest gated same-note, lowest free, oldest (strict > keeps lowest on ties)
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (!hit && gate_q[i] && (note_q[i] == ev_c.note)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!free && !gate_q[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IDX_W'(i);
      end
    end
    sel_idx = hit ? hit_idx : (free ? free_idx : old_idx);

    if (ev_c.alloff) begin
      gate_d = '0;
    end else if (ev_c.on) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        if (IDX_W'(i) == sel_idx) begin
          gate_d[i] = 1'b1;
          note_d[i] = ev_c.note;
          vel_d[i]  = ev_c.vel;
          age_d[i]  = '0;
        end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
          age_d[i] = age_q[i] + AGE_BITS'(1);
        end
      end
      update_d     = 1'b1;
      update_idx_d = sel_idx;
    end else if (ev_c.off) begin
      // Note and velocity are held so the release phase keeps its pitch
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        if (gate_q[i] && (note_q[i] == ev_c.note)) begin
          gate_d[i] = 1'b0;
          if (!off_hit) begin
            off_hit = 1'b1;
            off_idx = IDX_W'(i);
          end
        end
      end
      if (off_hit) begin
        update_d     = 1'b1;
        update_idx_d = off_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_q       <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      gate_q       <= gate_d;
      update_q     <= update_d;
      update_idx_q <= update_idx_d;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        note_q[i] <= note_d[i];
        vel_q[i]  <= vel_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  // Flatten per-voice registers onto the packed output buses
  always_comb begin
    voice_note     = '0;
    voice_velocity = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      voice_note[7*i +: 7]     = note_q[i];
      voice_velocity[7*i +: 7] = vel_q[i];
    end
  end

  assign voice_gate       = gate_q;
  assign voice_update     = update_q;
  assign voice_update_idx = update_idx_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench for midi_voice_allocator: an OMNI instance and a
// channel-0-only instance share one byte stream; both are compared every
// cycle against a message-level reference model.
module tb_midi_voice_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  midi_data;
  logic        midi_valid;

  logic [3:0]  g0, g1;
  logic [27:0] n0, n1, v0, v1;
  logic        u0, u1;
  logic [1:0]  i0, i1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  midi_voice_allocator #(.NUM_VOICES(4), .AGE_BITS(4), .OMNI(1'b1), .CHANNEL(0)) dut_omni (
    .clk(clk), .rst_n(rst_n), .midi_data(midi_data), .midi_valid(midi_valid),
    .voice_gate(g0), .voice_note(n0), .voice_velocity(v0),
    .voice_update(u0), .voice_update_idx(i0)
  );

  midi_voice_allocator #(.NUM_VOICES(4), .AGE_BITS(4), .OMNI(1'b0), .CHANNEL(0)) dut_ch0 (
    .clk(clk), .rst_n(rst_n), .midi_data(midi_data), .midi_valid(midi_valid),
    .voice_gate(g1), .voice_note(n1), .voice_velocity(v1),
    .voice_update(u1), .voice_update_idx(i1)
  );

  // Reference model state, [instance][voice]; instance 1 accepts channel 0 only
  int mg [2][4];
  int mn [2][4];
  int mv [2][4];
  int ma [2][4];
  int m_rs [2];
  int m_cnt [2];
  int m_d1 [2];
  int e_upd [2];
  int e_idx [2];

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  gate;
    logic        upd;
    logic [1:0]  idx;
    logic [27:0] notes;
  } vec_t;

  vec_t tbl [21];

  localparam logic [27:0] NA = {7'h00, 7'h00, 7'h00, 7'h3C};
  localparam logic [27:0] NB = {7'h00, 7'h00, 7'h40, 7'h3C};
  localparam logic [27:0] NC = {7'h00, 7'h3E, 7'h40, 7'h3C};
  localparam logic [27:0] ND = {7'h41, 7'h3E, 7'h40, 7'h3C};
  localparam logic [27:0] NE = {7'h41, 7'h3E, 7'h40, 7'h43};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        mg[m][i] = 0; mn[m][i] = 0; mv[m][i] = 0; ma[m][i] = 0;
      end
      m_rs[m] = -1; m_cnt[m] = 0; m_d1[m] = 0; e_upd[m] = 0; e_idx[m] = 0;
    end
  endfunction

  function automatic void model_on(input int m, input int note, input int vel);
    int sel;
    int best;
    sel  = -1;
    best = -1;
    for (int i = 0; i < 4; i++) if (sel < 0 && mg[m][i] != 0 && mn[m][i] == note) sel = i;
    if (sel < 0) for (int i = 0; i < 4; i++) if (sel < 0 && mg[m][i] == 0) sel = i;
    if (sel < 0) begin
      for (int i = 0; i < 4; i++) begin
        if (ma[m][i] > best) begin
          best = ma[m][i];
          sel  = i;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i != sel && mg[m][i] != 0) ma[m][i] = (ma[m][i] >= 15) ? 15 : ma[m][i] + 1;
    end
    mg[m][sel] = 1; mn[m][sel] = note; mv[m][sel] = vel; ma[m][sel] = 0;
    e_upd[m] = 1;
    e_idx[m] = sel;
  endfunction

  function automatic void model_off(input int m, input int note);
    int first;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      if (mg[m][i] != 0 && mn[m][i] == note) begin
        mg[m][i] = 0;
        if (first < 0) first = i;
      end
    end
    if (first >= 0) begin
      e_upd[m] = 1;
      e_idx[m] = first;
    end
  endfunction

  function automatic void model_byte(input int m, input logic v, input logic [7:0] b);
    int hi;
    int ch;
    e_upd[m] = 0;
    if (!v || b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_rs[m] = -1; m_cnt[m] = 0;
      return;
    end
    if (b[7]) begin
      m_rs[m] = int'(b); m_cnt[m] = 0;
      return;
    end
    if (m_rs[m] < 0) return;
    hi = m_rs[m] / 16;
    ch = m_rs[m] % 16;
    if (hi == 12 || hi == 13) return;
    if (m_cnt[m] == 0) begin
      m_d1[m] = int'(b); m_cnt[m] = 1;
      return;
    end
    m_cnt[m] = 0;
    if (m == 1 && ch != 0) return;
    if (hi == 9 && b != 8'h00) model_on(m, m_d1[m], int'(b));
    else if (hi == 8 || hi == 9) model_off(m, m_d1[m]);
    else if (hi == 11 && m_d1[m] == 123) begin
      for (int i = 0; i < 4; i++) mg[m][i] = 0;
    end
  endfunction

  task automatic check_inst(input int m, input logic [3:0] g, input logic [27:0] n,
                            input logic [27:0] v, input logic u, input logic [1:0] ix);
    logic [3:0]  pg;
    logic [27:0] pn;
    logic [27:0] pv;
    string       tag;
    for (int i = 0; i < 4; i++) begin
      pg[i]        = (mg[m][i] != 0);
      pn[7*i +: 7] = 7'(mn[m][i]);
      pv[7*i +: 7] = 7'(mv[m][i]);
    end
    tag = (m == 0) ? "omni" : "ch0";
    chk($sformatf("%s gate", tag), 32'(g), 32'(pg));
    chk($sformatf("%s note", tag), 32'(n), 32'(pn));
    chk($sformatf("%s velocity", tag), 32'(v), 32'(pv));
    chk($sformatf("%s update", tag), 32'(u), 32'(e_upd[m]));
    if (e_upd[m] != 0) chk($sformatf("%s update_idx", tag), 32'(ix), 32'(e_idx[m]));
  endtask

  // Drive one cycle at the falling edge, then compare at the next falling edge
  task automatic step(input logic v, input logic [7:0] b);
    midi_valid = v;
    midi_data  = b;
    model_byte(0, v, b);
    model_byte(1, v, b);
    @(negedge clk);
    check_inst(0, g0, n0, v0, u0, i0);
    check_inst(1, g1, n1, v1, u1, i1);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    midi_valid = 1'b0;
    midi_data  = 8'h00;
    repeat (2) @(negedge clk);
    model_reset();
    chk("reset gate", 32'({g1, g0}), 32'd0);
    chk("reset update", 32'({u1, u0}), 32'd0);
    chk("reset note/vel", 32'(n0 | v0 | n1 | v1), 32'd0);
    check_inst(0, g0, n0, v0, u0, i0);
    check_inst(1, g1, n1, v1, u1, i1);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  initial begin
    rst_n      = 1'b0;
    midi_valid = 1'b0;
    midi_data  = 8'h00;

    tbl[0]  = '{8'h90, 4'b0000, 1'b0, 2'd0, 28'h0};
    tbl[1]  = '{8'h3C, 4'b0000, 1'b0, 2'd0, 28'h0};
    tbl[2]  = '{8'h64, 4'b0001, 1'b1, 2'd0, NA};
    tbl[3]  = '{8'h40, 4'b0001, 1'b0, 2'd0, NA};
    tbl[4]  = '{8'h50, 4'b0011, 1'b1, 2'd1, NB};
    tbl[5]  = '{8'h3E, 4'b0011, 1'b0, 2'd0, NB};
    tbl[6]  = '{8'h70, 4'b0111, 1'b1, 2'd2, NC};
    tbl[7]  = '{8'h41, 4'b0111, 1'b0, 2'd0, NC};
    tbl[8]  = '{8'h20, 4'b1111, 1'b1, 2'd3, ND};
    tbl[9]  = '{8'h43, 4'b1111, 1'b0, 2'd0, ND};
    tbl[10] = '{8'h7F, 4'b1111, 1'b1, 2'd0, NE};
    tbl[11] = '{8'h80, 4'b1111, 1'b0, 2'd0, NE};
    tbl[12] = '{8'h40, 4'b1111, 1'b0, 2'd0, NE};
    tbl[13] = '{8'h00, 4'b1101, 1'b1, 2'd1, NE};
    tbl[14] = '{8'h43, 4'b1101, 1'b0, 2'd0, NE};
    tbl[15] = '{8'h11, 4'b1100, 1'b1, 2'd0, NE};
    tbl[16] = '{8'h90, 4'b1100, 1'b0, 2'd0, NE};
    tbl[17] = '{8'h3E, 4'b1100, 1'b0, 2'd0, NE};
    tbl[18] = '{8'h00, 4'b1000, 1'b1, 2'd2, NE};
    tbl[19] = '{8'h41, 4'b1000, 1'b0, 2'd0, NE};
    tbl[20] = '{8'h05, 4'b1000, 1'b1, 2'd3, NE};

    @(negedge clk);
    do_reset();

    // Directed table: fill, running status, steal, note-off forms, retrigger
    for (int k = 0; k < 21; k++) begin
      send(tbl[k].data);
      chk($sformatf("tbl[%0d] gate", k), 32'(g0), 32'(tbl[k].gate));
      chk($sformatf("tbl[%0d] update", k), 32'(u0), 32'(tbl[k].upd));
      chk($sformatf("tbl[%0d] notes", k), 32'(n0), 32'(tbl[k].notes));
      if (tbl[k].upd) chk($sformatf("tbl[%0d] idx", k), 32'(i0), 32'(tbl[k].idx));
    end

    // Realtime bytes interleaved inside messages
    do_reset();
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h64);
    chk("rt on gate0", 32'(g0[0]), 32'd1);
    chk("rt on update", 32'(u0), 32'd1);
    chk("rt on note0", 32'(n0[6:0]), 32'h3C);
    chk("rt on vel0", 32'(v0[6:0]), 32'h64);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h00);
    chk("rt off gate0", 32'(g0[0]), 32'd0);
    chk("rt off note held", 32'(n0[6:0]), 32'h3C);
    chk("rt off update", 32'(u0), 32'd1);
    chk("rt off idx", 32'(i0), 32'd0);

    // Channel filter and All Notes Off
    do_reset();
    send(8'h91); send(8'h3C); send(8'h64);
    chk("foreign ch gate", 32'(g1), 32'd0);
    chk("foreign ch update", 32'(u1), 32'd0);
    send(8'h3E); send(8'h64);
    chk("foreign running gate", 32'(g1), 32'd0);
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h64); send(8'h40); send(8'h64);
    chk("ch0 three gated", 32'(g1), 32'b0111);
    send(8'hB0); send(8'h7B); send(8'h00);
    chk("all notes off gate", 32'(g1), 32'd0);
    chk("all notes off no pulse", 32'(u1), 32'd0);

    // Age saturation decides the steal: v0 true age 16 must read as 15, not wrap to 0
    do_reset();
    send(8'h90);
    send(8'h3C); send(8'h01); send(8'h3D); send(8'h01);
    send(8'h3E); send(8'h01); send(8'h3F); send(8'h01);
    for (int k = 0; k < 13; k++) begin
      send(8'h3F); send(8'h02);
    end
    send(8'h50); send(8'h01);
    chk("sat steal update", 32'(u0), 32'd1);
    chk("sat steal idx", 32'(i0), 32'd0);
    chk("sat steal note", 32'(n0[6:0]), 32'h50);

    // Reset in the middle of a message discards it and running status
    do_reset();
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    chk("post-reset gate", 32'(g0), 32'd0);
    chk("post-reset update", 32'(u0), 32'd0);
    chk("post-reset note", 32'(n0), 32'd0);

    // Randomized stream against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int         r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        step(1'b0, 8'($urandom));
      end else if (r < 30) begin
        case ($urandom_range(0, 9))
          0, 1, 2: b = 8'h90;
          3, 4:    b = 8'h80;
          5:       b = 8'hB0;
          6:       b = 8'hC0;
          7:       b = 8'hF8;
          8:       b = 8'hF0;
          default: b = 8'hE0;
        endcase
        if (b < 8'hF0 && $urandom_range(0, 3) == 0) b = b | 8'h01;
        send(b);
      end else begin
        r = int'($urandom_range(0, 9));
        if (r < 5)       b = 8'h3C + 8'($urandom_range(0, 5));
        else if (r < 7)  b = 8'h00;
        else if (r == 7) b = 8'h7B;
        else             b = 8'($urandom_range(0, 127));
        send(b);
      end
    end

    midi_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
